truth_table_sweeper: RTL

Stimulus sequencer sitting directly upstream of the 3-input combinational truth-table stage (Y = A·B + ~(A+C)). On a start pulse it drives {A,B,C} through all eight combinations 000→111, holding each for a programmable dwell. It can optionally capture the returned Y into an 8-bit truth-table register and flag a match against an expected column. It is used for on-board self-check and simulation of the combinational stage.

---
 rtl/truth_table_sweeper.sv | 122 ++++++++++++
 1 files changed

// File: rtl/truth_table_sweeper.sv
// Stimulus sequencer for the 3-input truth-table stage: sweeps {A,B,C} 000..111 with a
// programmable dwell per combination. Define TT_CAPTURE_EN to capture y_in and compare it to EXPECT.
module truth_table_sweeper #(
    parameter int unsigned DWELL  = 4,
    parameter logic [7:0]  EXPECT = 8'hC5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       y_in,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic [2:0] idx,
    output logic       busy,
    output logic       done,
    output logic [7:0] table_out,
    output logic       pass
);

    // state    | meaning
    // ST_IDLE  | stimulus parked at 000, waiting for start
    // ST_DRIVE | presenting combination idx, counting its dwell
    // ST_DONE  | sweep finished, stimulus held at 111, results held
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(DWELL - 1);

    state_t     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] cnt_q, cnt_d;
    logic       capture;
    logic       clear_tbl;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= 3'd0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        capture   = 1'b0;
        clear_tbl = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
            idx_d   = 3'd0;
            cnt_d   = 8'd0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_d   = ST_DRIVE;
                        idx_d     = 3'd0;
                        cnt_d     = 8'd0;
                        clear_tbl = 1'b1;
                    end
                end
                ST_DRIVE: begin
                    if (cnt_q == CNT_LAST) begin
                        capture = 1'b1;
                        if (idx_q == 3'd7) begin
                            state_d = ST_DONE;
                        end else begin
                            idx_d = idx_q + 3'd1;
                            cnt_d = 8'd0;
                        end
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    idx_d   = 3'd0;
                    cnt_d   = 8'd0;
                end
            endcase
        end
    end

    // Stimulus is the index register itself, so it moves on the same edge as idx.
    assign {A, B, C} = idx_q;
    assign idx       = idx_q;
    assign busy      = (state_q == ST_DRIVE);
    assign done      = (state_q == ST_DONE);

`ifdef TT_CAPTURE_EN
    logic [7:0] table_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            table_q <= 8'h00;
        end else if (clear_tbl) begin
            table_q <= 8'h00;
        end else if (capture) begin
            table_q[idx_q] <= y_in;
        end
    end

    assign table_out = table_q;
    assign pass      = done && (table_q == EXPECT);
`else
    logic unused_capture;
    assign unused_capture = y_in ^ capture ^ clear_tbl;
    assign table_out      = 8'h00;
    assign pass           = 1'b0;
`endif

endmodule
